// File: rtl/rtc_bcd_core_if.sv
// Board-side bundle for the BCD real-time-clock core: mode select, four raw set
// buttons in, BCD time digits and status strobes out.
interface rtc_bcd_core_if;
  logic       mode_12h;
  logic       min_add;
  logic       min_reduce;
  logic       hour_add;
  logic       hour_reduce;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] hour_tens;
  logic [3:0] hour_ones;
  logic       pm;
  logic       tick_1hz;
  logic       hour_chime;

  modport master (
    output mode_12h, min_add, min_reduce, hour_add, hour_reduce,
    input  sec_tens, sec_ones, min_tens, min_ones, hour_tens, hour_ones,
    input  pm, tick_1hz, hour_chime
  );

  modport slave (
    input  mode_12h, min_add, min_reduce, hour_add, hour_reduce,
    output sec_tens, sec_ones, min_tens, min_ones, hour_tens, hour_ones,
    output pm, tick_1hz, hour_chime
  );
endinterface

// File: rtl/rtc_bcd_core.sv
// Single-clock BCD real-time clock: 1 Hz enable prescaler, hh:mm:ss BCD counters,
// debounced/auto-repeating set buttons, 12/24h display mapping and hourly chime.
module rtc_bcd_core #(
  parameter int CLK_HZ          = 50000000,
  parameter int DEBOUNCE_MS     = 20,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100
) (
  input logic           clk,
  input logic           reset,
  rtc_bcd_core_if.slave bus
);

  localparam int CYC_MS   = CLK_HZ / 1000;
  localparam int DB_CYC   = DEBOUNCE_MS * CYC_MS;
  localparam int DLY_CYC  = REPEAT_DELAY_MS * CYC_MS;
  localparam int RATE_CYC = REPEAT_RATE_MS * CYC_MS;
  localparam int RMAX     = (DLY_CYC > RATE_CYC) ? DLY_CYC : RATE_CYC;
  localparam int PW       = $clog2(CLK_HZ);
  localparam int DBW      = $clog2(DB_CYC + 1);
  localparam int RW       = $clog2(RMAX + 1);

  localparam int B_MIN_ADD  = 0;
  localparam int B_MIN_RED  = 1;
  localparam int B_HOUR_ADD = 2;
  localparam int B_HOUR_RED = 3;

  function automatic logic [7:0] f_bcd_inc(input logic [7:0] v, input logic [7:0] vmax);
    if (v == vmax) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] f_bcd_dec(input logic [7:0] v, input logic [7:0] vmax);
    if (v == 8'h00) return vmax;
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // An adjust event owns its field for the cycle; a pending carry is dropped.
  function automatic logic [7:0] f_field_next(input logic [7:0] v, input logic [7:0] vmax,
                                              input logic add, input logic red,
                                              input logic carry);
    if (add && !red) return f_bcd_inc(v, vmax);
    if (red && !add) return f_bcd_dec(v, vmax);
    if (add && red)  return v;
    if (carry)       return f_bcd_inc(v, vmax);
    return v;
  endfunction

  function automatic logic [7:0] f_hour12(input logic [7:0] h);
    logic [4:0] b;
    b = 5'(h[7:4]) * 5'd10 + 5'(h[3:0]);
    if (b == 5'd0) b = 5'd12;
    else if (b > 5'd12) b = b - 5'd12;
    if (b >= 5'd10) return {4'd1, 4'(b - 5'd10)};
    return {4'd0, 4'(b)};
  endfunction

  logic [PW-1:0]  r_presc;
  logic           r_tick;
  logic [3:0]     w_raw;
  logic [3:0]     r_sync1;
  logic [3:0]     r_sync2;
  logic [3:0]     r_deb;
  logic [3:0]     r_rate;
  logic [3:0]     w_evt;
  logic [DBW-1:0] r_dbc [4];
  logic [RW-1:0]  r_rep [4];
  logic [7:0]     r_sec;
  logic [7:0]     r_min;
  logic [7:0]     r_hour;
  logic           r_chime;
  logic           w_min_carry;
  logic           w_min_adj;
  logic           w_hour_carry;
  logic [7:0]     w_disp_hour;

  assign w_raw = {bus.hour_reduce, bus.hour_add, bus.min_reduce, bus.min_add};

  // Tick is registered one count early so it is high while the count is CLK_HZ-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      if (r_presc == PW'(CLK_HZ - 1)) r_presc <= '0;
      else                            r_presc <= r_presc + PW'(1);
      r_tick <= (r_presc == PW'(CLK_HZ - 2));
    end
  end

  // Event on the first debounced-high cycle (timer still 0) and whenever the
  // timer reaches the current delay/rate target.
  always_comb begin
    w_evt = '0;
    for (int i = 0; i < 4; i++) begin
      w_evt[i] = r_deb[i] &&
                 ((r_rep[i] == '0) ||
                  (r_rep[i] == (r_rate[i] ? RW'(RATE_CYC) : RW'(DLY_CYC))));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_rate  <= '0;
      for (int i = 0; i < 4; i++) begin
        r_dbc[i] <= '0;
        r_rep[i] <= '0;
      end
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_dbc[i] <= '0;
        end else if (r_dbc[i] == DBW'(DB_CYC - 1)) begin
          r_deb[i] <= r_sync2[i];
          r_dbc[i] <= '0;
        end else begin
          r_dbc[i] <= r_dbc[i] + DBW'(1);
        end

        if (!r_deb[i]) begin
          r_rep[i]  <= '0;
          r_rate[i] <= 1'b0;
        end else if (w_evt[i] && (r_rep[i] != '0)) begin
          r_rep[i]  <= RW'(1);
          r_rate[i] <= 1'b1;
        end else begin
          r_rep[i] <= r_rep[i] + RW'(1);
        end
      end
    end
  end

  assign w_min_carry  = r_tick && (r_sec == 8'h59);
  assign w_min_adj    = w_evt[B_MIN_ADD] || w_evt[B_MIN_RED];
  assign w_hour_carry = w_min_carry && !w_min_adj && (r_min == 8'h59);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sec   <= 8'h00;
      r_min   <= 8'h00;
      r_hour  <= 8'h00;
      r_chime <= 1'b0;
    end else begin
      if (r_tick) r_sec <= f_bcd_inc(r_sec, 8'h59);
      r_min  <= f_field_next(r_min, 8'h59, w_evt[B_MIN_ADD], w_evt[B_MIN_RED], w_min_carry);
      r_hour <= f_field_next(r_hour, 8'h23, w_evt[B_HOUR_ADD], w_evt[B_HOUR_RED],
                             w_hour_carry);
      r_chime <= w_hour_carry;
    end
  end

  assign w_disp_hour = bus.mode_12h ? f_hour12(r_hour) : r_hour;

  assign bus.sec_tens   = r_sec[7:4];
  assign bus.sec_ones   = r_sec[3:0];
  assign bus.min_tens   = r_min[7:4];
  assign bus.min_ones   = r_min[3:0];
  assign bus.hour_tens  = w_disp_hour[7:4];
  assign bus.hour_ones  = w_disp_hour[3:0];
  assign bus.pm         = (r_hour >= 8'h12);
  assign bus.tick_1hz   = r_tick;
  assign bus.hour_chime = r_chime;

endmodule

// File: tb/tb_rtc_bcd_core.sv
// Directed bench for rtc_bcd_core: three instances share one clock so the long
// second-59 scenarios and the mid-operation reset run in parallel.
module tb_rtc_bcd_core;
  localparam int N = 3;
  localparam logic [3:0] MA = 4'b0001;
  localparam logic [3:0] MR = 4'b0010;
  localparam logic [3:0] HA = 4'b0100;
  localparam logic [3:0] HR = 4'b1000;

  typedef struct packed {
    logic [23:0] t;
    logic        pm;
    logic        tick;
    logic        chime;
  } st_t;

  typedef struct {
    int         off;
    logic [7:0] mins;
  } rep_vec_t;

  typedef struct {
    int         hr;
    logic [7:0] d24;
    logic [7:0] d12;
    logic       pm;
  } disp_vec_t;

  logic         clk = 1'b0;
  logic [N-1:0] rst;
  logic [N-1:0] mode;
  logic [3:0]   btn [N];
  int           cyc;
  int           total;
  int           bad;
  int           chime_cnt [N];
  rep_vec_t     rep_tab [10];
  disp_vec_t    disp_tab [5];

  always #5 clk = ~clk;

  rtc_bcd_core_if if_a ();
  rtc_bcd_core_if if_b ();
  rtc_bcd_core_if if_c ();

  assign if_a.mode_12h = mode[0];
  assign if_a.min_add = btn[0][0];
  assign if_a.min_reduce = btn[0][1];
  assign if_a.hour_add = btn[0][2];
  assign if_a.hour_reduce = btn[0][3];
  assign if_b.mode_12h = mode[1];
  assign if_b.min_add = btn[1][0];
  assign if_b.min_reduce = btn[1][1];
  assign if_b.hour_add = btn[1][2];
  assign if_b.hour_reduce = btn[1][3];
  assign if_c.mode_12h = mode[2];
  assign if_c.min_add = btn[2][0];
  assign if_c.min_reduce = btn[2][1];
  assign if_c.hour_add = btn[2][2];
  assign if_c.hour_reduce = btn[2][3];

  rtc_bcd_core #(.CLK_HZ(1000), .DEBOUNCE_MS(2), .REPEAT_DELAY_MS(10), .REPEAT_RATE_MS(4))
    u_a (.clk(clk), .reset(rst[0]), .bus(if_a));
  rtc_bcd_core #(.CLK_HZ(1000), .DEBOUNCE_MS(2), .REPEAT_DELAY_MS(10), .REPEAT_RATE_MS(4))
    u_b (.clk(clk), .reset(rst[1]), .bus(if_b));
  rtc_bcd_core #(.CLK_HZ(1000), .DEBOUNCE_MS(2), .REPEAT_DELAY_MS(10), .REPEAT_RATE_MS(4))
    u_c (.clk(clk), .reset(rst[2]), .bus(if_c));

  function automatic st_t st(input int k);
    st_t s;
    case (k)
      0: s = '{{if_a.hour_tens, if_a.hour_ones, if_a.min_tens, if_a.min_ones,
                if_a.sec_tens, if_a.sec_ones}, if_a.pm, if_a.tick_1hz, if_a.hour_chime};
      1: s = '{{if_b.hour_tens, if_b.hour_ones, if_b.min_tens, if_b.min_ones,
                if_b.sec_tens, if_b.sec_ones}, if_b.pm, if_b.tick_1hz, if_b.hour_chime};
      default: s = '{{if_c.hour_tens, if_c.hour_ones, if_c.min_tens, if_c.min_ones,
                      if_c.sec_tens, if_c.sec_ones}, if_c.pm, if_c.tick_1hz, if_c.hour_chime};
    endcase
    return s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      for (int k = 0; k < N; k++) if (st(k).chime) chime_cnt[k]++;
    end
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step(1);
  endtask

  // Debounced press: event lands 4 cycles after the raw edge, release before any repeat.
  task automatic press(input int k, input logic [3:0] m);
    btn[k] = m;
    step(5);
    btn[k] = 4'b0000;
    step(8);
  endtask

  initial begin
    int terr;
    int tcnt;
    int r;
    int cur;
    int t_rst;
    logic tk;

    rep_tab[0] = '{4, 8'h00};  rep_tab[1] = '{5, 8'h01};
    rep_tab[2] = '{14, 8'h01}; rep_tab[3] = '{15, 8'h02};
    rep_tab[4] = '{18, 8'h02}; rep_tab[5] = '{19, 8'h03};
    rep_tab[6] = '{22, 8'h03}; rep_tab[7] = '{23, 8'h04};
    rep_tab[8] = '{27, 8'h05}; rep_tab[9] = '{40, 8'h05};
    disp_tab[0] = '{0,  8'h00, 8'h12, 1'b0};
    disp_tab[1] = '{11, 8'h11, 8'h11, 1'b0};
    disp_tab[2] = '{12, 8'h12, 8'h12, 1'b1};
    disp_tab[3] = '{13, 8'h13, 8'h01, 1'b1};
    disp_tab[4] = '{23, 8'h23, 8'h11, 1'b1};

    total = 0;
    bad = 0;
    cyc = 0;
    rst = '1;
    mode = '0;
    for (int k = 0; k < N; k++) begin
      btn[k] = 4'b0000;
      chime_cnt[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = '0;

    // Reset state and the 1 Hz enable
    chk("rst_time", st(0).t, 24'h000000);
    chk("rst_pm", st(0).pm, 1'b0);
    chk("rst_tick", st(0).tick, 1'b0);
    chk("rst_chime", st(0).chime, 1'b0);
    mode[0] = 1'b1;
    #1;
    chk("rst_hour12", st(0).t[23:16], 8'h12);
    mode[0] = 1'b0;
    #1;
    terr = 0;
    tcnt = 0;
    for (int c = 0; c < 3000; c++) begin
      tk = st(0).tick;
      if (tk) tcnt++;
      if (tk != (c == 999 || c == 1999 || c == 2999)) terr++;
      step(1);
    end
    chk("tick_pattern_errs", terr, 0);
    chk("tick_count", tcnt, 3);
    chk("time_after_3000", st(0).t, 24'h000003);

    // Preload: A -> 23:59, B -> 10:59, C -> 07:30
    press(0, HR);
    press(0, MR);
    chk("a_preload", st(0).t[23:8], 16'h2359);
    for (int i = 0; i < 10; i++) press(1, HA);
    press(1, MR);
    chk("b_preload", st(1).t[23:8], 16'h1059);
    for (int i = 0; i < 7; i++) press(2, HA);
    for (int i = 0; i < 30; i++) press(2, MR);
    chk("c_preload", st(2).t[23:8], 16'h0730);

    // Reset C mid-repeat with hour_add held
    run_to(15300);
    chk("c_at_073015", st(2).t, 24'h073015);
    btn[2] = HA;
    step(16);
    chk("c_mid_repeat_hour", st(2).t[23:16], 8'h09);
    rst[2] = 1'b1;
    #1;
    chk("c_async_clear", st(2).t, 24'h000000);
    step(3);
    rst[2] = 1'b0;
    t_rst = cyc;
    run_to(t_rst + 4);
    chk("c_no_early_press", st(2).t, 24'h000000);
    run_to(t_rst + 5);
    chk("c_held_press", st(2).t, 24'h010000);
    btn[2] = 4'b0000;
    step(20);
    chk("c_single_press", st(2).t, 24'h010000);

    // Natural hour rollover on A; adjust-vs-carry collision on B
    run_to(58500);
    for (int k = 0; k < N; k++) chime_cnt[k] = 0;
    chk("a_235958", st(0).t, 24'h235958);
    chk("a_pm_before", st(0).pm, 1'b1);
    run_to(59500);
    chk("a_235959", st(0).t, 24'h235959);
    chk("b_105959", st(1).t, 24'h105959);
    run_to(59995);
    btn[1] = MA;
    run_to(59999);
    chk("a_tick_59999", st(0).tick, 1'b1);
    run_to(60000);
    chk("a_midnight", st(0).t, 24'h000000);
    chk("a_pm_after", st(0).pm, 1'b0);
    chk("a_chime_now", st(0).chime, 1'b1);
    chk("b_adjust_wins", st(1).t, 24'h100000);
    chk("b_chime_now", st(1).chime, 1'b0);
    run_to(60001);
    btn[1] = 4'b0000;
    chk("a_chime_width", st(0).chime, 1'b0);
    run_to(60020);
    chk("a_chime_count", chime_cnt[0], 1);
    chk("b_chime_count", chime_cnt[1], 0);
    press(1, HA | HR);
    chk("b_add_reduce_same", st(1).t[23:16], 8'h10);
    press(1, HA);
    chk("b_hour_add", st(1).t[23:16], 8'h11);

    // Bounce then hold on A: one press plus four repeats
    btn[0] = MA; step(1);
    btn[0] = 4'b0000; step(1);
    btn[0] = MA; step(1);
    btn[0] = 4'b0000; step(1);
    btn[0] = MA;
    r = cyc;
    for (int i = 0; i < 10; i++) begin
      while (cyc < r + rep_tab[i].off) begin
        step(1);
        if (cyc == r + 26) btn[0] = 4'b0000;
      end
      chk($sformatf("repeat_min_at_%0d", rep_tab[i].off), st(0).t[15:8], rep_tab[i].mins);
    end

    // 12/24h display mapping on a freshly reset A
    rst[0] = 1'b1;
    step(2);
    rst[0] = 1'b0;
    cur = 0;
    for (int i = 0; i < 5; i++) begin
      while (cur < disp_tab[i].hr) begin
        press(0, HA);
        cur++;
      end
      mode[0] = 1'b0;
      #1;
      chk($sformatf("disp24_h%0d", disp_tab[i].hr), st(0).t[23:16], disp_tab[i].d24);
      chk($sformatf("pm24_h%0d", disp_tab[i].hr), st(0).pm, disp_tab[i].pm);
      mode[0] = 1'b1;
      #1;
      chk($sformatf("disp12_h%0d", disp_tab[i].hr), st(0).t[23:16], disp_tab[i].d12);
      chk($sformatf("pm12_h%0d", disp_tab[i].hr), st(0).pm, disp_tab[i].pm);
      mode[0] = 1'b0;
    end
    press(0, HA);
    chk("hour_add_wrap", st(0).t[23:16], 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rtc_bcd_core.md
Name: rtc_bcd_core

Overview:
Single-clock-domain BCD real-time-clock core, replacing the derived-clock second/minute/hour counter chain with one clock plus clock-enable ticks.
- Generates an internal 1 Hz enable and keeps hh:mm:ss in BCD.
- Debounces the four set buttons and adds auto-repeat on held buttons.
- Offers a 12/24-hour display mode and an hourly chime pulse.
- Sits between the board clock/buttons and the existing seven-segment display decoders.

Parameters:
CLK_HZ, 50000000, clk frequency in Hz; must be a multiple of 1000 and at least 1000
DEBOUNCE_MS, 20, time a button must be stable before its debounced level changes
REPEAT_DELAY_MS, 500, hold time after a press before the first auto-repeat event
REPEAT_RATE_MS, 100, period between auto-repeat events while the button is still held

Ports:
clk  in  1  system clock, CLK_HZ
reset  in  1  asynchronous, active-high; clears all state
mode_12h  in  1  1 = 12-hour display, 0 = 24-hour display; may change at any time
min_add  in  1  raw button, active-high, asynchronous to clk
min_reduce  in  1  raw button, active-high
hour_add  in  1  raw button, active-high
hour_reduce  in  1  raw button, active-high
sec_tens  out  4  BCD seconds tens, range 0-5
sec_ones  out  4  BCD seconds ones, range 0-9
min_tens  out  4  BCD minutes tens, range 0-5
min_ones  out  4  BCD minutes ones, range 0-9
hour_tens  out  4  BCD display-hour tens
hour_ones  out  4  BCD display-hour ones
pm  out  1  1 when internal hour >= 12; valid in both modes
tick_1hz  out  1  one-cycle pulse, once per second
hour_chime  out  1  one-cycle pulse on a natural hour rollover

Behaviour:
Reset:
- Time 00:00:00; prescaler 0; tick_1hz, hour_chime and pm 0.
- All debouncers in the released state; repeat timers 0.
- Display hour reads 00 in 24h mode, 12 in 12h mode.

Prescaler:
- Counts 0..CLK_HZ-1 and wraps.
- tick_1hz is registered and asserted for exactly one cycle when the count equals CLK_HZ-1.

Counting (on the cycle tick_1hz=1; new values visible the next cycle):
- sec_ones 9->0 with carry into sec_tens; seconds 59->00 produces a minute carry.
- Minutes 59->00 produces an hour carry; internal hours 23->00.
- The internal hour is always 24h BCD, 00-23.

Buttons (identical per button):
- Two-flop synchronizer, then a debounce counter. The debounced level changes only after the synchronized input differs from it for DEBOUNCE_MS*(CLK_HZ/1000) consecutive cycles; any bounce restarts the count.
- Debounced rising edge produces one adjust event.
- While held, the first repeat event fires REPEAT_DELAY_MS after the press, then one every REPEAT_RATE_MS.
- Release stops repeats and clears the repeat timer.
- Events are single-cycle internal strobes.

Adjust:
- min_add: minutes +1, 59->00, no hour carry. min_reduce: minutes -1, 00->59.
- hour_add: hours +1, 23->00. hour_reduce: hours -1, 00->23.
- Seconds and prescaler are unaffected by any adjust.
- add and reduce events on the same field in the same cycle: field unchanged.
- Adjust event coinciding with a tick carry into the same field: the adjust result wins and the carry is discarded. Lower fields still roll over normally. A discarded minute carry generates no hour carry.

Display mapping (combinational from registers):
- 24h: display hour = internal hour.
- 12h: internal 00->12, 01-11 unchanged, 12->12, 13-23 -> 01-11.
- pm = internal hour >= 12 in both modes.

hour_chime:
- Asserted for one cycle, concurrent with the first visible xx:00:00, only when it was reached via a seconds/minutes carry chain.
- Never asserted by an adjust, including an adjust that lands on minute 00.

Reset mid-operation:
- Asynchronous clear of all state, including in-flight debounce and repeat timers.
- A button held through reset deassertion is treated as a new press once it is stable for the debounce time.

Test Plan:
(Use CLK_HZ=1000, DEBOUNCE_MS=2, REPEAT_DELAY_MS=10, REPEAT_RATE_MS=4.)
- Reset then run 3000 cycles -> tick_1hz pulses at cycles 999, 1999, 2999, each 1 cycle wide; time reads 00:00:03.
- Preload 23:59:58 via hour_reduce x1 and min_reduce x1, then run 2 ticks -> 00:00:00; hour_chime pulses exactly once; pm goes 1->0.
- Bounce min_add (1-cycle glitches, then stable high for 2+ cycles) -> exactly one minute increment; hold 22 more cycles -> repeats at press+10 and press+14, +18, +22 (total 5 increments).
- mode_12h=1, step hours 00, 11, 12, 13, 23 -> display 12/pm0, 11/pm0, 12/pm1, 01/pm1, 11/pm1; mode_12h=0 shows 00, 11, 12, 13, 23.
- At 10:59:59, min_add event in the same cycle as a tick -> 10:00:00 (minutes 59+1 wraps to 00, hour carry discarded, seconds roll); no hour_chime; simultaneous hour_add + hour_reduce -> hour unchanged.
- Assert reset mid-repeat at 07:30:15 with hour_add held -> outputs 00:00:00 immediately; after release with the button still held, one increment after debounce -> 01:00:00.
